// File: rtl/rob_ooo.sv
// Reorder buffer: contiguous multi-slot reservation, out-of-order completion,
// in-order multi-entry retirement, and partial/full flush recovery.
module rob_ooo #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int INS_COUNT = 2,
  parameter int EXT_COUNT = 2,
  parameter int PTR_W     = $clog2(DEPTH)
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 reserve_req,
  input  logic [$clog2(INS_COUNT+1)-1:0]       reserve_count,
  output logic                                 reserve_grant,
  output logic [INS_COUNT-1:0][PTR_W-1:0]      reserved_slots,
  input  logic [INS_COUNT-1:0]                 write_valid,
  input  logic [INS_COUNT-1:0][PTR_W-1:0]      write_slot,
  input  logic [INS_COUNT-1:0][DATA_W-1:0]     write_data,
  output logic [EXT_COUNT-1:0]                 head_valid,
  output logic [EXT_COUNT-1:0][DATA_W-1:0]     head_data,
  input  logic [$clog2(EXT_COUNT+1)-1:0]       consume_count,
  input  logic                                 flush,
  input  logic [PTR_W-1:0]                     flush_slot,
  input  logic                                 flush_all,
  output logic [PTR_W:0]                       used_count,
  output logic [PTR_W:0]                       free_count,
  output logic                                 empty,
  output logic                                 full
);
  localparam int RC_W = $clog2(INS_COUNT+1);
  localparam int CC_W = $clog2(EXT_COUNT+1);

  logic [PTR_W:0]     ins_ptr_q, ins_ptr_d, ext_ptr_q, ext_ptr_d;
  logic [DEPTH-1:0]   done_q, done_d;
  logic [DATA_W-1:0]  data_q [DEPTH];
  logic [DATA_W-1:0]  data_d [DEPTH];
  logic [PTR_W-1:0]   ins_slot, ext_slot, flush_off;
  logic               flush_ok, flush_hit;
  logic [CC_W-1:0]    ret_n;
  logic [INS_COUNT-1:0] wr_occ, wr_en;

  // Reserve handshake: reserve_grant is a same-cycle combinational answer to
  // reserve_req; allocation happens on the clock edge where both are high.
  always_comb begin
    used_count    = ins_ptr_q - ext_ptr_q;
    free_count    = (PTR_W+1)'(DEPTH) - used_count;
    empty         = (used_count == '0);
    full          = (used_count == (PTR_W+1)'(DEPTH));
    ins_slot      = ins_ptr_q[PTR_W-1:0];
    ext_slot      = ext_ptr_q[PTR_W-1:0];
    reserve_grant = reserve_req && ((PTR_W+1)'(reserve_count) <= free_count)
                    && !flush && !flush_all;
    for (int i = 0; i < INS_COUNT; i++) begin
      reserved_slots[i] = ins_slot + PTR_W'(i);
    end
  end

  always_comb begin
    logic chain;
    chain      = 1'b1;
    head_valid = '0;
    ret_n      = '0;
    for (int j = 0; j < EXT_COUNT; j++) begin
      head_data[j]  = data_q[ext_slot + PTR_W'(j)];
      head_valid[j] = chain && ((PTR_W+1)'(j) < used_count)
                      && done_q[ext_slot + PTR_W'(j)];
      chain         = head_valid[j];
    end
    for (int j = 0; j < EXT_COUNT; j++) begin
      if ((CC_W'(j) < consume_count) && head_valid[j]) ret_n = ret_n + CC_W'(1);
    end
  end

  // Occupancy and squash tests are done as offsets from the oldest entry.
  always_comb begin
    logic [PTR_W-1:0] wr_off;
    flush_off = flush_slot - ext_slot;
    flush_ok  = ({1'b0, flush_off} < used_count);
    flush_hit = flush && !flush_all && flush_ok;
    wr_off    = '0;
    for (int i = 0; i < INS_COUNT; i++) begin
      wr_off    = write_slot[i] - ext_slot;
      wr_occ[i] = ({1'b0, wr_off} < used_count);
      wr_en[i]  = write_valid[i] && wr_occ[i] && !flush_all
                  && !(flush_hit && (wr_off > flush_off));
    end
  end

  always_comb begin
    logic [PTR_W:0] keep;
    done_d = done_q;
    for (int i = 0; i < INS_COUNT; i++) begin
      if (wr_en[i]) done_d[write_slot[i]] = 1'b1;
    end
    for (int j = 0; j < EXT_COUNT; j++) begin
      if (CC_W'(j) < ret_n) done_d[ext_slot + PTR_W'(j)] = 1'b0;
    end
    ext_ptr_d = ext_ptr_q + (PTR_W+1)'(ret_n);
    ins_ptr_d = ins_ptr_q;
    keep      = {1'b0, flush_off} + (PTR_W+1)'(1);
    if (flush_all) begin
      ins_ptr_d = ext_ptr_d;
    end else if (flush_hit) begin
      // Never let the flush point fall behind entries retiring this cycle.
      if (keep < (PTR_W+1)'(ret_n)) ins_ptr_d = ext_ptr_d;
      else                          ins_ptr_d = ext_ptr_q + keep;
    end else if (reserve_grant) begin
      ins_ptr_d = ins_ptr_q + (PTR_W+1)'(reserve_count);
      for (int i = 0; i < INS_COUNT; i++) begin
        if (RC_W'(i) < reserve_count) done_d[ins_slot + PTR_W'(i)] = 1'b0;
      end
    end
  end

  always_comb begin
    data_d = data_q;
    for (int i = 0; i < INS_COUNT; i++) begin
      if (wr_en[i]) data_d[write_slot[i]] = write_data[i];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ins_ptr_q <= '0;
      ext_ptr_q <= '0;
      done_q    <= '0;
    end else begin
      ins_ptr_q <= ins_ptr_d;
      ext_ptr_q <= ext_ptr_d;
      done_q    <= done_d;
    end
  end

  // Payload storage carries no reset; done bits gate every read.
  always_ff @(posedge clock) begin
    data_q <= data_d;
  end

  for (genvar gi = 0; gi < INS_COUNT; gi++) begin : g_wr_chk
    a_wr_occupied: assert property (@(posedge clock) disable iff (!reset_n)
      write_valid[gi] |-> wr_occ[gi]);
  end

  a_flush_occupied: assert property (@(posedge clock) disable iff (!reset_n)
    (flush && !flush_all) |-> flush_ok);

endmodule
